// File: rtl/controle_elevador_pkg.sv
// Shared definitions for the elevator controller: state encodings,
// default timing constants and the timer width helper.
package controle_elevador_pkg;

   localparam logic [1:0] PARADO       = 2'd0;
   localparam logic [1:0] SUBINDO      = 2'd1;
   localparam logic [1:0] DESCENDO     = 2'd2;
   localparam logic [1:0] PORTA_ABERTA = 2'd3;

   localparam int N_ANDARES_DEF    = 10;
   localparam int CICLOS_ANDAR_DEF = 8;
   localparam int CICLOS_PORTA_DEF = 4;

   // Timer must hold values up to max(CICLOS_ANDAR, CICLOS_PORTA)-1; never narrower than 1 bit.
   function automatic int larg_timer(input int ciclos_andar, input int ciclos_porta);
      int maior;
      maior = (ciclos_andar > ciclos_porta) ? ciclos_andar : ciclos_porta;
      return (maior > 1) ? $clog2(maior) : 1;
   endfunction

endpackage

// File: rtl/controle_elevador_sobeoudesce.sv
// Direction decision: s=1 when the requested floor lies above the current one,
// i.e. the sign of (andar - botao). Equality reports 0 ("desce").
module sobeoudesce (
   input  logic [3:0] andar,
   input  logic [3:0] botao,
   output logic       s
);

   logic signed [4:0] dif_s;

   assign dif_s = $signed({1'b0, andar}) - $signed({1'b0, botao});
   assign s     = (dif_s < 5'sd0);

endmodule

// File: rtl/controle_elevador.sv
// Single-request elevator controller: travels floor by floor toward a latched
// target, opens the door on arrival, then returns to idle.
module controle_elevador
   import controle_elevador_pkg::*;
#(
   parameter int N_ANDARES    = N_ANDARES_DEF,
   parameter int CICLOS_ANDAR = CICLOS_ANDAR_DEF,
   parameter int CICLOS_PORTA = CICLOS_PORTA_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] botao,
   input  logic       botao_valido,
   output logic [3:0] andar,
   output logic       sobe,
   output logic       desce,
   output logic       porta_aberta,
   output logic       chegou,
   output logic       ocupado
);

   localparam int              TW        = larg_timer(CICLOS_ANDAR, CICLOS_PORTA);
   localparam logic [4:0]      LIM_ANDAR = 5'(N_ANDARES);
   localparam logic [TW-1:0]   FIM_ANDAR = TW'(CICLOS_ANDAR - 1);
   localparam logic [TW-1:0]   FIM_PORTA = TW'(CICLOS_PORTA - 1);

   logic [1:0]    state_q, state_d;
   logic [3:0]    andar_q, andar_d;
   logic [3:0]    alvo_q,  alvo_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          chegou_q, chegou_d;

   logic          dir_sobe;
   logic          pedido_ok_s;
   logic [3:0]    andar_acima_s;
   logic [3:0]    andar_abaixo_s;

   sobeoudesce u_dir (
      .andar (andar_q),
      .botao (botao),
      .s     (dir_sobe)
   );

   assign pedido_ok_s    = botao_valido && ({1'b0, botao} < LIM_ANDAR);
   assign andar_acima_s  = andar_q + 4'd1;
   assign andar_abaixo_s = andar_q - 4'd1;

   // Next-state logic for the controller state, position, target, timer and arrival pulse.
   always_comb begin
      state_d  = state_q;
      andar_d  = andar_q;
      alvo_d   = alvo_q;
      timer_d  = timer_q;
      chegou_d = 1'b0;
      case (state_q)
         PARADO: begin
            if (pedido_ok_s) begin
               alvo_d  = botao;
               timer_d = '0;
               // Equality must be caught here: the direction unit reports "desce" on it.
               if (botao == andar_q) begin
                  state_d  = PORTA_ABERTA;
                  chegou_d = 1'b1;
               end else if (dir_sobe) begin
                  state_d = SUBINDO;
               end else begin
                  state_d = DESCENDO;
               end
            end else begin
               state_d = PARADO;
            end
         end
         SUBINDO: begin
            if (timer_q == FIM_ANDAR) begin
               timer_d = '0;
               andar_d = andar_acima_s;
               if (andar_acima_s == alvo_q) begin
                  state_d  = PORTA_ABERTA;
                  chegou_d = 1'b1;
               end else begin
                  state_d = SUBINDO;
               end
            end else begin
               timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         DESCENDO: begin
            if (timer_q == FIM_ANDAR) begin
               timer_d = '0;
               andar_d = andar_abaixo_s;
               if (andar_abaixo_s == alvo_q) begin
                  state_d  = PORTA_ABERTA;
                  chegou_d = 1'b1;
               end else begin
                  state_d = DESCENDO;
               end
            end else begin
               timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         PORTA_ABERTA: begin
            if (timer_q == FIM_PORTA) begin
               timer_d = '0;
               state_d = PARADO;
            end else begin
               timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = PARADO;
            timer_d = '0;
         end
      endcase
   end

   // Controller registers; reset aborts any trip or door cycle with no resume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= PARADO;
         andar_q  <= 4'd0;
         alvo_q   <= 4'd0;
         timer_q  <= '0;
         chegou_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         andar_q  <= andar_d;
         alvo_q   <= alvo_d;
         timer_q  <= timer_d;
         chegou_q <= chegou_d;
      end
   end

   assign andar        = andar_q;
   assign chegou       = chegou_q;
   assign sobe         = (state_q == SUBINDO);
   assign desce        = (state_q == DESCENDO);
   assign porta_aberta = (state_q == PORTA_ABERTA);
   assign ocupado      = (state_q != PARADO);

endmodule
